// File: rtl/multdiv_sequencer.sv
// Sequencer for the multi-cycle multiply/divide unit in the execute stage.
// Optional BUSY watchdog is compiled in with `define MULTDIV_WATCHDOG_EN.
module multdiv_sequencer #(
  parameter int TIMEOUT = 40
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_op_mul,
  input  logic        i_op_div,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  input  logic [4:0]  i_dest_reg,
  input  logic        i_kill,
  output logic        o_stall,
  output logic        o_md_ctrl_mult,
  output logic        o_md_ctrl_div,
  output logic [31:0] o_md_operand_a,
  output logic [31:0] o_md_operand_b,
  input  logic [31:0] i_md_result,
  input  logic        i_md_exception,
  input  logic        i_md_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_result_reg,
  output logic        o_result_valid,
  output logic [1:0]  o_dbg_state
);

  // Handshake: start pulses and o_result_valid are single-cycle strobes with no
  // back-pressure; i_md_ready is a single-cycle strobe honoured only in BUSY.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_is_div;
  logic [4:0]  r_dest;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_result;
  logic [4:0]  r_result_reg;
  logic        w_accept;
  logic        w_timeout;
  logic        w_capture;
  logic        w_exc;

  assign w_accept = (r_state == S_IDLE) & (i_op_mul | i_op_div) & !i_kill;

`ifdef MULTDIV_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wd_cnt;

  // Counter holds n-1 during the n-th BUSY cycle, so the TIMEOUT-th cycle gives up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_BUSY) & (r_wd_cnt == CW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
`endif

  assign w_capture = (r_state == S_BUSY) & !i_kill & (i_md_ready | w_timeout);
  // A timeout without ready is reported exactly like a unit exception.
  assign w_exc     = i_md_ready ? i_md_exception : 1'b1;

  always_comb begin
    w_next_state   = r_state;
    o_stall        = 1'b0;
    o_md_ctrl_mult = 1'b0;
    o_md_ctrl_div  = 1'b0;
    o_result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          o_stall      = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_stall        = 1'b1;
        o_md_ctrl_mult = !r_is_div;
        o_md_ctrl_div  = r_is_div;
        w_next_state   = S_BUSY;
      end
      S_BUSY: begin
        o_stall = 1'b1;
        if (w_capture) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        o_result_valid = 1'b1;
        w_next_state   = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (i_kill) begin
      w_next_state = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_is_div     <= 1'b0;
      r_dest       <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_result_reg <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_is_div <= !i_op_mul;
        r_dest   <= i_dest_reg;
        r_op_a   <= i_operand_a;
        r_op_b   <= i_operand_b;
      end
      if (w_capture) begin
        r_result     <= w_exc ? (r_is_div ? 32'd5 : 32'd4) : i_md_result;
        r_result_reg <= w_exc ? 5'd30 : r_dest;
      end
    end
  end

  assign o_md_operand_a = r_op_a;
  assign o_md_operand_b = r_op_b;
  assign o_result       = r_result;
  assign o_result_reg   = r_result_reg;
  assign o_dbg_state    = r_state;

endmodule
